// File: rtl/mux8_arbiter.sv
// Two-channel arbiter that steers an external 8-bit mux, waits for the mux to settle, and captures one sample per grant.
// Optional build macro MUX8_ARBITER_PRIO_A_EN: fixed priority (A wins every tie); otherwise round-robin on ties.
module mux8_arbiter #(
    parameter int SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       req_b,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       sel,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic [7:0] q,
    output logic       q_ch,
    output logic       q_valid,
    input  logic       q_ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC);
    localparam bit         HAS_SETTLE  = (SETTLE_CYC > 0);

    state_t     state_reg;
    state_t     state_next;
    logic       sel_reg;
    logic       sel_next;
    logic [3:0] cnt_reg;
    logic [3:0] cnt_next;
    logic [7:0] q_reg;
    logic [7:0] q_next;
    logic       q_ch_reg;
    logic       q_ch_next;
    logic       last_reg;
    logic       last_next;
    logic       choice;
    logic       chosen_req;
    logic [7:0] mux_out;

    // Model of the external mux8 so the captured value matches what sel steers.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_mux_bit
            assign mux_out[gi] = sel_reg ? b[gi] : a[gi];
        end
    endgenerate

`ifdef MUX8_ARBITER_PRIO_A_EN
    assign choice = ~req_a;
`else
    // On a tie the channel that did not finish the previous transfer wins.
    assign choice = (req_a && req_b) ? ~last_reg : req_b;
`endif

    assign chosen_req = sel_reg ? req_b : req_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            sel_reg   <= 1'b0;
            cnt_reg   <= 4'd0;
            q_reg     <= 8'd0;
            q_ch_reg  <= 1'b0;
            last_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            cnt_reg   <= cnt_next;
            q_reg     <= q_next;
            q_ch_reg  <= q_ch_next;
            last_reg  <= last_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        cnt_next   = cnt_reg;
        q_next     = q_reg;
        q_ch_next  = q_ch_reg;
        last_next  = last_reg;
        case (state_reg)
            IDLE: begin
                if (req_a || req_b) begin
                    sel_next = choice;
                    if (HAS_SETTLE && (choice != sel_reg)) begin
                        state_next = SETTLE;
                        cnt_next   = SETTLE_LOAD;
                    end else begin
                        state_next = CAPTURE;
                    end
                end
            end
            SETTLE: begin
                // A withdrawn request abandons the transfer but leaves the mux where it is.
                if (!chosen_req) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end else if (cnt_reg <= 4'd1) begin
                    state_next = CAPTURE;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            CAPTURE: begin
                q_next     = mux_out;
                q_ch_next  = sel_reg;
                state_next = OUTPUT;
            end
            OUTPUT: begin
                if (q_ready) begin
                    last_next  = q_ch_reg;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign sel     = sel_reg;
    assign gnt_a   = (state_reg == CAPTURE) && !sel_reg;
    assign gnt_b   = (state_reg == CAPTURE) && sel_reg;
    assign q       = q_reg;
    assign q_ch    = q_ch_reg;
    assign q_valid = (state_reg == OUTPUT);
    assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_mux8_arbiter.sv
// Directed bench for mux8_arbiter with SETTLE_CYC=2; outputs sampled 1ns after each rising edge.
module tb_mux8_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_a;
    logic       req_b;
    logic [7:0] a;
    logic [7:0] b;
    logic       sel;
    logic       gnt_a;
    logic       gnt_b;
    logic [7:0] q;
    logic       q_ch;
    logic       q_valid;
    logic       q_ready;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    mux8_arbiter #(.SETTLE_CYC(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_a   (req_a),
        .req_b   (req_b),
        .a       (a),
        .b       (b),
        .sel     (sel),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b),
        .q       (q),
        .q_ch    (q_ch),
        .q_valid (q_valid),
        .q_ready (q_ready),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return gnt_a;
            1:       return gnt_b;
            default: return q_valid;
        endcase
    endfunction

    // Steps until the selected output goes high (at most 30 cycles), checking exclusivity on the way.
    task automatic wait_for(input int which, input string tag);
        int k = 0;
        while (sig(which) !== 1'b1 && k < 30) begin
            step();
            chk("gnt_exclusive", {7'd0, gnt_a & gnt_b}, 8'd0);
            chk("valid_gnt_exclusive", {7'd0, q_valid & (gnt_a | gnt_b)}, 8'd0);
            k++;
        end
        chk(tag, {7'd0, sig(which)}, 8'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sel"}, {7'd0, sel}, 8'd0);
        chk({tag, "_q"}, q, 8'd0);
        chk({tag, "_q_ch"}, {7'd0, q_ch}, 8'd0);
        chk({tag, "_q_valid"}, {7'd0, q_valid}, 8'd0);
        chk({tag, "_gnt_a"}, {7'd0, gnt_a}, 8'd0);
        chk({tag, "_gnt_b"}, {7'd0, gnt_b}, 8'd0);
        chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
    endtask

    logic rr_exp [4];

    initial begin
`ifdef MUX8_ARBITER_PRIO_A_EN
        rr_exp = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        rr_exp = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; a = 8'h00; b = 8'h00; q_ready = 1'b1;
        step();
        step();
        chk_reset_outputs("reset");

        // Single A request with sel already 0: no settle, grant after the first edge.
        rst = 1'b0; req_a = 1'b1; a = 8'h3C;
        step();
        chk("a_gnt_a", {7'd0, gnt_a}, 8'd1);
        chk("a_gnt_b", {7'd0, gnt_b}, 8'd0);
        chk("a_busy", {7'd0, busy}, 8'd1);
        chk("a_qv_during_gnt", {7'd0, q_valid}, 8'd0);
        req_a = 1'b0;
        step();
        chk("a_q_valid", {7'd0, q_valid}, 8'd1);
        chk("a_q", q, 8'h3C);
        chk("a_q_ch", {7'd0, q_ch}, 8'd0);
        chk("a_gnt_gone", {7'd0, gnt_a}, 8'd0);
        step();
        chk("a_idle_valid", {7'd0, q_valid}, 8'd0);
        chk("a_idle_busy", {7'd0, busy}, 8'd0);

        // B request switches sel and must spend two cycles settling.
        req_b = 1'b1; b = 8'hA5;
        step();
        chk("b_sel", {7'd0, sel}, 8'd1);
        chk("b_settle1_gnt", {7'd0, gnt_b}, 8'd0);
        chk("b_settle1_busy", {7'd0, busy}, 8'd1);
        step();
        chk("b_settle2_gnt", {7'd0, gnt_b}, 8'd0);
        step();
        chk("b_gnt_b", {7'd0, gnt_b}, 8'd1);
        chk("b_gnt_a", {7'd0, gnt_a}, 8'd0);
        req_b = 1'b0;
        step();
        chk("b_gnt_once", {7'd0, gnt_b}, 8'd0);
        chk("b_q_valid", {7'd0, q_valid}, 8'd1);
        chk("b_q", q, 8'hA5);
        chk("b_q_ch", {7'd0, q_ch}, 8'd1);
        step();
        chk("b_idle_valid", {7'd0, q_valid}, 8'd0);

        // Both requesting continuously: alternation, with an idle gap between samples.
        a = 8'h11; b = 8'h22; req_a = 1'b1; req_b = 1'b1;
        for (int t = 0; t < 4; t++) begin
            wait_for(2, "rr_q_valid");
            chk("rr_q_ch", {7'd0, q_ch}, {7'd0, rr_exp[t]});
            chk("rr_q", q, rr_exp[t] ? 8'h22 : 8'h11);
            step();
            chk("rr_gap", {7'd0, q_valid}, 8'd0);
        end
        req_a = 1'b0; req_b = 1'b0;

        // Held output while downstream stalls, even as the source keeps changing.
        q_ready = 1'b0; req_a = 1'b1; a = 8'h5A;
        wait_for(0, "hold_gnt_a");
        req_a = 1'b0;
        wait_for(2, "hold_q_valid");
        for (int t = 0; t < 5; t++) begin
            a = a + 8'd1;
            step();
            chk("hold_q", q, 8'h5A);
            chk("hold_q_ch", {7'd0, q_ch}, 8'd0);
            chk("hold_q_valid", {7'd0, q_valid}, 8'd1);
            chk("hold_no_gnt", {7'd0, gnt_a | gnt_b}, 8'd0);
        end
        q_ready = 1'b1;
        step();
        chk("hold_release", {7'd0, q_valid}, 8'd0);

        // B withdraws its request mid-settle: back to idle, no grant, sel stays on B.
        req_b = 1'b1;
        step();
        chk("drop_sel", {7'd0, sel}, 8'd1);
        chk("drop_busy", {7'd0, busy}, 8'd1);
        req_b = 1'b0;
        step();
        chk("drop_idle", {7'd0, busy}, 8'd0);
        chk("drop_sel_kept", {7'd0, sel}, 8'd1);
        for (int t = 0; t < 3; t++) begin
            step();
            chk("drop_no_gnt", {7'd0, gnt_b}, 8'd0);
            chk("drop_no_valid", {7'd0, q_valid}, 8'd0);
        end

        // Reset during OUTPUT discards the sample.
        q_ready = 1'b0; req_a = 1'b1; a = 8'h77;
        wait_for(0, "rst_gnt_a");
        req_a = 1'b0;
        wait_for(2, "rst_q_valid");
        chk("rst_q_pre", q, 8'h77);
        rst = 1'b1;
        step();
        chk_reset_outputs("rst_output");
        rst = 1'b0; q_ready = 1'b1;
        step();
        chk("rst_after_valid", {7'd0, q_valid}, 8'd0);

        // First tie after reset goes to A.
        a = 8'hC3; b = 8'h3C; req_a = 1'b1; req_b = 1'b1;
        step();
        chk("tie_gnt_a", {7'd0, gnt_a}, 8'd1);
        chk("tie_gnt_b", {7'd0, gnt_b}, 8'd0);
        req_a = 1'b0; req_b = 1'b0;
        step();
        chk("tie_q", q, 8'hC3);
        chk("tie_q_ch", {7'd0, q_ch}, 8'd0);
        step();
        chk("tie_idle", {7'd0, busy}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
